// File: rtl/mdu_ctrl.sv
// mdu_ctrl: E-stage multiply/divide unit with its own sequencing.
// Owns the HI/LO registers, holds busy for a fixed latency per operation
// and requests a D-stage freeze while a dependent instruction is waiting.
//
// Optional feature macro: MDU_MADD_EN (MADD/MADDU/MSUB/MSUBU decode and
// the 64-bit multiply-accumulate adder). Undefined: md_op 7..10 act as NONE.
//
// Ports:
//   clk_i        system clock, rising edge
//   reset_i      synchronous active-high reset
//   start_i      E-stage MDU instruction valid (single-cycle)
//   md_op_i      operation code (see localparams below)
//   rs_val_i     first operand (dividend / multiplicand / MTHI-MTLO source)
//   rt_val_i     second operand (divisor / multiplier)
//   d_md_use_i   D-stage instruction touches the MDU or HI/LO
//   busy_o       operation in progress
//   stall_o      freeze request to hazard unit (combinational)
//   done_o       one-cycle pulse when a multi-cycle result commits
//   hi_o, lo_o   HI/LO registers
//
// state | meaning
// IDLE  | no operation pending; MTHI/MTLO write directly
// MUL   | multiply (or multiply-accumulate) latency countdown
// DIV   | divide latency countdown
module mdu_ctrl #(
   parameter int unsigned MULT_LAT = 5,
   parameter int unsigned DIV_LAT  = 10
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        start_i,
   input  logic [3:0]  md_op_i,
   input  logic [31:0] rs_val_i,
   input  logic [31:0] rt_val_i,
   input  logic        d_md_use_i,
   output logic        busy_o,
   output logic        stall_o,
   output logic        done_o,
   output logic [31:0] hi_o,
   output logic [31:0] lo_o
);

   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MTHI  = 4'd5;
   localparam logic [3:0] OP_MTLO  = 4'd6;
   localparam logic [3:0] OP_MADD  = 4'd7;
   localparam logic [3:0] OP_MADDU = 4'd8;
   localparam logic [3:0] OP_MSUB  = 4'd9;
   localparam logic [3:0] OP_MSUBU = 4'd10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;
   logic [31:0] res_hi_q, res_hi_d;
   logic [31:0] res_lo_q, res_lo_d;
   logic        done_q, done_d;

   logic        is_mul, is_div, mul_sgn, div_sgn;
   logic [63:0] a64, b64, prod, mul_res, div_res;
   logic        a_neg, b_neg;
   logic [31:0] mag_a, mag_b, q_mag, r_mag, quo, rem;

   // Operation decode
   always_comb begin
      is_mul  = 1'b0;
      is_div  = 1'b0;
      mul_sgn = 1'b0;
      div_sgn = 1'b0;
      case (md_op_i)
         OP_MULT:  begin is_mul = 1'b1; mul_sgn = 1'b1; end
         OP_MULTU: is_mul = 1'b1;
         OP_DIV:   begin is_div = 1'b1; div_sgn = 1'b1; end
         OP_DIVU:  is_div = 1'b1;
`ifdef MDU_MADD_EN
         OP_MADD,
         OP_MSUB:  begin is_mul = 1'b1; mul_sgn = 1'b1; end
         OP_MADDU,
         OP_MSUBU: is_mul = 1'b1;
`endif
         default: ;
      endcase
   end

   // 64-bit product; low 64 bits of the extended multiply are exact for
   // both signed and unsigned operands.
   always_comb begin
      a64  = mul_sgn ? {{32{rs_val_i[31]}}, rs_val_i} : {32'd0, rs_val_i};
      b64  = mul_sgn ? {{32{rt_val_i[31]}}, rt_val_i} : {32'd0, rt_val_i};
      prod = a64 * b64;
      mul_res = prod;
`ifdef MDU_MADD_EN
      // Accumulate against HI/LO as they stand at start.
      if (md_op_i == OP_MADD || md_op_i == OP_MADDU)
         mul_res = {hi_q, lo_q} + prod;
      else if (md_op_i == OP_MSUB || md_op_i == OP_MSUBU)
         mul_res = {hi_q, lo_q} - prod;
`endif
   end

   // Divide on magnitudes, then restore signs. This also gives the wrapped
   // 0x80000000 quotient for 0x80000000 / -1 without overflow trouble.
   always_comb begin
      a_neg = div_sgn & rs_val_i[31];
      b_neg = div_sgn & rt_val_i[31];
      mag_a = a_neg ? (32'd0 - rs_val_i) : rs_val_i;
      mag_b = b_neg ? (32'd0 - rt_val_i) : rt_val_i;
      q_mag = 32'd0;
      r_mag = 32'd0;
      if (mag_b != 32'd0) begin
         q_mag = mag_a / mag_b;
         r_mag = mag_a % mag_b;
      end
      quo = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
      rem = a_neg ? (32'd0 - r_mag) : r_mag;
      // Divide by zero leaves HI/LO untouched at commit.
      div_res = (rt_val_i == 32'd0) ? {hi_q, lo_q} : {rem, quo};
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      res_hi_d = res_hi_q;
      res_lo_d = res_lo_q;
      done_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               if (is_mul) begin
                  {res_hi_d, res_lo_d} = mul_res;
                  cnt_d   = 4'(MULT_LAT);
                  state_d = ST_MUL;
               end else if (is_div) begin
                  {res_hi_d, res_lo_d} = div_res;
                  cnt_d   = 4'(DIV_LAT);
                  state_d = ST_DIV;
               end else if (md_op_i == OP_MTHI) begin
                  hi_d = rs_val_i;
               end else if (md_op_i == OP_MTLO) begin
                  lo_d = rs_val_i;
               end
            end
         end
         ST_MUL, ST_DIV: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               hi_d    = res_hi_q;
               lo_d    = res_lo_q;
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q  <= ST_IDLE;
         cnt_q    <= 4'd0;
         hi_q     <= 32'd0;
         lo_q     <= 32'd0;
         res_hi_q <= 32'd0;
         res_lo_q <= 32'd0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         res_hi_q <= res_hi_d;
         res_lo_q <= res_lo_d;
         done_q   <= done_d;
      end
   end

   assign busy_o  = (state_q != ST_IDLE);
   assign stall_o = d_md_use_i & (busy_o | (start_i & (is_mul | is_div)));
   assign done_o  = done_q;
   assign hi_o    = hi_q;
   assign lo_o    = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
module tb_mdu_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [3:0]  md_op;
   logic [31:0] rs_val, rt_val;
   logic        d_md_use;
   logic        busy, stall, done;
   logic [31:0] hi, lo;

   int n_tests = 0;
   int n_fail  = 0;

   mdu_ctrl #(.MULT_LAT(5), .DIV_LAT(10)) dut (
      .clk_i      (clk),
      .reset_i    (reset),
      .start_i    (start),
      .md_op_i    (md_op),
      .rs_val_i   (rs_val),
      .rt_val_i   (rt_val),
      .d_md_use_i (d_md_use),
      .busy_o     (busy),
      .stall_o    (stall),
      .done_o     (done),
      .hi_o       (hi),
      .lo_o       (lo)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance to 1 time unit after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      start  = 1'b1;
      md_op  = op;
      rs_val = a;
      rt_val = b;
   endtask

   // Issue a multi-cycle op, check busy over cycles 1..lat and the done cycle.
   // Returns in the done cycle so a following op can be issued back-to-back.
   task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int lat,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      drive(op, a, b);
      step();
      start = 1'b0;
      for (int c = 1; c <= lat; c++) begin
         check({tag, ".busy"}, {63'd0, busy}, 64'd1);
         check({tag, ".nodone"}, {63'd0, done}, 64'd0);
         step();
      end
      check({tag, ".busy_end"}, {63'd0, busy}, 64'd0);
      check({tag, ".done"}, {63'd0, done}, 64'd1);
      check({tag, ".hi"}, {32'd0, hi}, {32'd0, exp_hi});
      check({tag, ".lo"}, {32'd0, lo}, {32'd0, exp_lo});
   endtask

   task automatic move(input string tag, input logic [3:0] op, input logic [31:0] a);
      drive(op, a, 32'd0);
      step();
      start = 1'b0;
      check({tag, ".busy"}, {63'd0, busy}, 64'd0);
      check({tag, ".done"}, {63'd0, done}, 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b1; start = 1'b0; md_op = 4'd0; rs_val = 32'd0; rt_val = 32'd0;
      d_md_use = 1'b1;
      step(); step();
      check("rst.busy", {63'd0, busy}, 64'd0);
      check("rst.done", {63'd0, done}, 64'd0);
      check("rst.stall", {63'd0, stall}, 64'd0);
      check("rst.hilo", {hi, lo}, 64'd0);
      reset = 1'b0;
      d_md_use = 1'b0;
      step();

      // -2 * 3 = -6
      run_op("mult", 4'd1, 32'hFFFFFFFE, 32'd3, 5, 32'hFFFFFFFF, 32'hFFFFFFFA);
      step();
      check("mult.done_once", {63'd0, done}, 64'd0);

      // Back-to-back: DIV issued in the DIVU done cycle.
      run_op("divu", 4'd4, 32'd100, 32'd7, 10, 32'd2, 32'd14);
      run_op("div", 4'd3, 32'hFFFFFFF9, 32'd2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
      run_op("divovf", 4'd3, 32'h80000000, 32'hFFFFFFFF, 10, 32'd0, 32'h80000000);
      step();

      // Stall window, plus an ignored start mid-operation.
      d_md_use = 1'b1;
      drive(4'd1, 32'd7, 32'd6);
      #1;
      check("stall.start", {63'd0, stall}, 64'd1);
      step();
      start = 1'b0;
      for (int c = 1; c <= 5; c++) begin
         check("stall.busy", {63'd0, stall}, 64'd1);
         check("stall.busylen", {63'd0, busy}, 64'd1);
         if (c == 2) drive(4'd1, 32'd100, 32'd100);
         step();
         start = 1'b0;
      end
      check("stall.done", {63'd0, stall}, 64'd0);
      check("stall.donepulse", {63'd0, done}, 64'd1);
      check("stall.busyoff", {63'd0, busy}, 64'd0);
      check("stall.hilo", {hi, lo}, 64'd42);
      d_md_use = 1'b0;
      step();

      // MTLO then divide by zero leaves HI/LO alone.
      move("mtlo", 4'd6, 32'h1234);
      check("mtlo.lo", {32'd0, lo}, 64'h1234);
      run_op("div0", 4'd3, 32'd55, 32'd0, 10, 32'd0, 32'h1234);
      // MTHI in the done cycle.
      move("mthi", 4'd5, 32'hCAFE);
      check("mthi.hi", {32'd0, hi}, 64'hCAFE);
      step();

      // Reset in the 4th busy cycle.
      drive(4'd3, 32'd50, 32'd5);
      step();
      start = 1'b0;
      step(); step(); step();
      check("rstmid.busy4", {63'd0, busy}, 64'd1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("rstmid.busy", {63'd0, busy}, 64'd0);
      check("rstmid.hilo", {hi, lo}, 64'd0);
      for (int c = 0; c < 12; c++) begin
         check("rstmid.nodone", {63'd0, done}, 64'd0);
         step();
      end

      move("mtlo5", 4'd6, 32'd5);
`ifdef MDU_MADD_EN
      run_op("madd", 4'd7, 32'd2, 32'd3, 5, 32'd0, 32'd11);
      run_op("msubu", 4'd10, 32'd1, 32'd12, 5, 32'hFFFFFFFF, 32'hFFFFFFFF);
      step();
`else
      d_md_use = 1'b1;
      drive(4'd7, 32'd2, 32'd3);
      #1;
      check("madd_off.stall", {63'd0, stall}, 64'd0);
      step();
      start = 1'b0;
      d_md_use = 1'b0;
      for (int c = 0; c < 6; c++) begin
         check("madd_off.busy", {63'd0, busy}, 64'd0);
         check("madd_off.done", {63'd0, done}, 64'd0);
         step();
      end
      check("madd_off.hilo", {hi, lo}, 64'd5);
`endif

      // Reset wins over a same-cycle start.
      reset = 1'b1;
      drive(4'd1, 32'd3, 32'd3);
      step();
      reset = 1'b0;
      start = 1'b0;
      check("rstprio.busy", {63'd0, busy}, 64'd0);
      step();
      check("rstprio.busy2", {63'd0, busy}, 64'd0);
      check("rstprio.hilo", {hi, lo}, 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
